// File: rtl/vec_mem_loader.sv
// Byte-stream to vector-memory loader: packs six bytes per word and issues one
// single-cycle write per word at consecutive addresses starting from a base.
module vec_mem_loader #(
  parameter int MEM_WORDS = 10923,
  parameter int LANES     = 6,
  parameter int AW        = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [AW-1:0]         base_addr,
  input  logic [AW-1:0]         word_count,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [AW-1:0]         mem_a,
  output logic [LANES-1:0][7:0] mem_wd,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  // state   | meaning
  // S_IDLE  | waiting for start; range check on start
  // S_FILL  | accepting bytes into the packing buffer
  // S_WRITE | one-cycle memory write of the packed word
  // S_DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {S_IDLE, S_FILL, S_WRITE, S_DONE} state_t;

  localparam logic [2:0]  LAST_LANE = 3'(LANES - 1);
  localparam logic [AW:0] MEM_LIMIT = MEM_WORDS[AW:0];

  state_t                 state;
  logic [2:0]             lane;
  logic [AW-1:0]          addr;
  logic [AW-1:0]          remaining;
  logic [LANES-1:0][7:0]  pack;
  logic [LANES-1:0][7:0]  word_next;
  logic [AW:0]            end_addr;
  logic                   accept;

  // Sum kept one bit wider so a base near the top of the address space cannot wrap.
  assign end_addr = {1'b0, base_addr} + {1'b0, word_count};
  assign accept   = in_valid & in_ready;

  always_comb begin
    word_next       = pack;
    word_next[lane] = in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      lane      <= '0;
      addr      <= '0;
      remaining <= '0;
      pack      <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_a     <= '0;
      mem_wd    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            if (word_count == '0) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else if (end_addr > MEM_LIMIT) begin
              err <= 1'b1;
            end else begin
              addr      <= base_addr;
              remaining <= word_count;
              lane      <= '0;
              state     <= S_FILL;
              in_ready  <= 1'b1;
              busy      <= 1'b1;
            end
          end
        end
        S_FILL: begin
          if (accept) begin
            pack <= word_next;
            if (lane == LAST_LANE) begin
              lane     <= '0;
              state    <= S_WRITE;
              in_ready <= 1'b0;
              mem_we   <= 1'b1;
              mem_a    <= addr;
              mem_wd   <= word_next;
            end else begin
              lane <= lane + 3'd1;
            end
          end
        end
        S_WRITE: begin
          if (remaining == AW'(1)) begin
            state <= S_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else begin
            addr      <= addr + AW'(1);
            remaining <= remaining - AW'(1);
            lane      <= '0;
            state     <= S_FILL;
            in_ready  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vec_mem_loader.sv
// Randomized bench for vec_mem_loader: a queue of expected (address, word) writes
// built from the bytes sent, plus per-transfer event counts and cycle timing.
module tb_vec_mem_loader;

  localparam int MEM_WORDS = 10923;
  localparam int AW        = 17;

  typedef struct {
    logic [AW-1:0] a;
    logic [47:0]   d;
  } wr_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [AW-1:0]    base_addr = '0;
  logic [AW-1:0]    word_count = '0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = '0;
  logic             in_ready;
  logic             mem_we;
  logic [AW-1:0]    mem_a;
  logic [5:0][7:0]  mem_wd;
  logic             busy;
  logic             done;
  logic             err;

  vec_mem_loader #(.MEM_WORDS(MEM_WORDS), .LANES(6), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .word_count(word_count),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .mem_we(mem_we),
    .mem_a(mem_a), .mem_wd(mem_wd), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  wr_t exp_q[$];
  logic [7:0] fixed_bytes[$];

  int we_cnt = 0, done_cnt = 0, err_cnt = 0, ready_cnt = 0, busy_cnt = 0;
  int first_we_cyc = -1, last_done_cyc = -1, last_err_cyc = -1;
  logic [AW-1:0] last_a = '0;
  logic [47:0]   last_wd = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Per-cycle compare against the expected-write queue and output relationships.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_we) begin
        we_cnt++;
        if (first_we_cyc < 0) first_we_cyc = cyc;
        last_a  = mem_a;
        last_wd = mem_wd;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got write a=%0d d=0x%0h, expected none", mem_a, mem_wd);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("write_addr", 64'(mem_a), 64'(e.a));
          chk("write_data", 64'(mem_wd), 64'(e.d));
        end
        chk("ready_busy_in_write", {62'd0, in_ready, busy}, 64'd1);
      end
      if (in_ready) begin
        ready_cnt++;
        chk("busy_in_fill", 64'(busy), 64'd1);
      end
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; last_done_cyc = cyc; end
      if (err)  begin err_cnt++;  last_err_cyc  = cyc; end
      if (done | err)
        chk("idle_on_pulse", {60'd0, in_ready, busy, mem_we, done & err}, 64'd0);
    end
  end

  task automatic feed(input logic [7:0] b[$], input int gap_pct, output bit ok);
    int idx = 0;
    int waited = 0;
    logic rdy;
    ok = 1'b1;
    while (idx < b.size()) begin
      in_valid = ($urandom_range(0, 99) >= gap_pct);
      in_data  = in_valid ? b[idx] : 8'($urandom);
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      if (in_valid && rdy) begin
        idx++;
        waited = 0;
      end else begin
        waited++;
        if (waited > 100) begin
          ok = 1'b0;
          break;
        end
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_xfer(input int base, input int count, input int gap_pct,
                          input bit timing, input bit intrude, input bit use_fixed);
    logic [7:0] bytes[$];
    int d0, e0, w0, r0, b0, sc;
    bit ok;
    bit is_err, is_xfer;
    wr_t w;
    logic [7:0] bv;
    is_err  = (count != 0) && (base + count > MEM_WORDS);
    is_xfer = (count != 0) && !is_err;
    if (is_xfer) begin
      for (int wi = 0; wi < count; wi++) begin
        w.a = AW'(base + wi);
        w.d = '0;
        for (int k = 0; k < 6; k++) begin
          bv = use_fixed ? fixed_bytes[k] : 8'($urandom);
          bytes.push_back(bv);
          w.d[8*k +: 8] = bv;
        end
        exp_q.push_back(w);
      end
    end
    d0 = done_cnt; e0 = err_cnt; w0 = we_cnt; r0 = ready_cnt; b0 = busy_cnt;
    first_we_cyc = -1;
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(base); word_count = AW'(count);
    sc = cyc;
    @(posedge clk); #1;
    start = 1'b0; base_addr = AW'($urandom); word_count = AW'($urandom);
    if (is_xfer) begin
      if (intrude) begin
        fork
          feed(bytes, gap_pct, ok);
          begin
            repeat (3) @(posedge clk);
            #1; start = 1'b1; base_addr = AW'(5); word_count = AW'(1);
            @(posedge clk); #1; start = 1'b0;
          end
        join
      end else begin
        feed(bytes, gap_pct, ok);
      end
      chk("feed_completed", 64'(ok), 64'd1);
      for (int i = 0; i < 20 && done_cnt == d0; i++) @(negedge clk);
      @(posedge clk); #1;
    end else begin
      repeat (3) @(posedge clk);
      #1;
    end
    chk("done_count", 64'(done_cnt - d0), is_err ? 64'd0 : 64'd1);
    chk("err_count", 64'(err_cnt - e0), 64'(is_err));
    chk("write_count", 64'(we_cnt - w0), is_xfer ? 64'(count) : 64'd0);
    if (!is_xfer) chk("no_ready_without_xfer", 64'(ready_cnt - r0), 64'd0);
    if (is_err) begin
      chk("busy_on_err", 64'(busy_cnt - b0), 64'd0);
      chk("err_cycle", 64'(last_err_cyc), 64'(sc + 1));
    end
    if (count == 0) chk("done_cycle_empty", 64'(last_done_cyc), 64'(sc + 1));
    if (is_xfer && timing) begin
      chk("first_write_cycle", 64'(first_we_cyc), 64'(sc + 7));
      chk("done_cycle", 64'(last_done_cyc), 64'(sc + 7 * count + 1));
      chk("busy_cycles", 64'(busy_cnt - b0), 64'(7 * count));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rb[$];
    bit ok;
    int w0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_ctrl", {59'd0, in_ready, mem_we, busy, done, err}, 64'd0);
    chk("reset_addr", 64'(mem_a), 64'd0);
    chk("reset_data", 64'(mem_wd), 64'd0);

    // Fixed bytes 11..66, back-to-back, single word at address 0.
    fixed_bytes = '{8'd11, 8'd22, 8'd33, 8'd44, 8'd55, 8'd66};
    run_xfer(0, 1, 0, 1'b1, 1'b0, 1'b1);
    chk("lit_addr", 64'(last_a), 64'd0);
    chk("lit_data", 64'(last_wd), 64'h42_37_2C_21_16_0B);

    run_xfer(100, 3, 40, 1'b0, 1'b0, 1'b0);
    chk("lit_last_addr_102", 64'(last_a), 64'd102);

    run_xfer(10920, 4, 0, 1'b0, 1'b0, 1'b0);
    run_xfer((1 << AW) - 1, 2, 0, 1'b0, 1'b0, 1'b0);
    run_xfer(10919, 4, 0, 1'b1, 1'b0, 1'b0);
    chk("lit_last_addr_10922", 64'(last_a), 64'd10922);

    run_xfer(77, 0, 0, 1'b0, 1'b0, 1'b0);

    // Reset after three bytes of the second word: only the first word is written.
    w0 = we_cnt;
    rb.delete();
    begin
      wr_t w;
      w.a = AW'(400);
      w.d = '0;
      for (int k = 0; k < 9; k++) begin
        rb.push_back(8'($urandom));
        if (k < 6) w.d[8*k +: 8] = rb[k];
      end
      exp_q.push_back(w);
    end
    @(posedge clk); #1;
    start = 1'b1; base_addr = AW'(400); word_count = AW'(3);
    @(posedge clk); #1;
    start = 1'b0;
    feed(rb, 0, ok);
    chk("reset_feed_completed", 64'(ok), 64'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_mid_idle", {60'd0, in_ready, busy, mem_we, done}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_partial_discarded", 64'(we_cnt - w0), 64'd1);
    run_xfer(300, 1, 30, 1'b0, 1'b0, 1'b0);

    run_xfer(50, 2, 0, 1'b1, 1'b1, 1'b0);
    chk("lit_intrude_last_addr", 64'(last_a), 64'd51);

    for (int t = 0; t < 25; t++) begin
      int b, c, g;
      if ($urandom_range(0, 3) == 0) b = MEM_WORDS - $urandom_range(0, 5);
      else b = $urandom_range(0, MEM_WORDS - 1);
      c = $urandom_range(0, 4);
      g = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(10, 60);
      run_xfer(b, c, g, g == 0, 1'b0, 1'b0);
    end

    repeat (5) @(posedge clk);
    chk("expected_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
